vcache_req_arbiter: RTL and testbench

- Shares one vcache request/response port among num_req_p requesters, e.g. several tile-side network endpoints feeding one vcache bank.
- Grants requests with a round-robin arbiter and forwards the winning cache packet to the vcache v_i/ready_o interface.
- Records the winner's id in an in-order tracking FIFO.
- Routes each vcache response (v_o/yumi_i) back to the requester at the FIFO head.

---
 rtl/vcache_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vcache_req_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vcache_req_arbiter.sv
// rtl/vcache_req_arbiter.sv - round-robin request arbiter sharing one vcache port, in-order response routing (optional stats: VCACHE_ARB_STATS_EN)
module vcache_req_arbiter #(
    parameter int num_req_p    = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int pkt_width_p  = 70,
    parameter int track_els_p  = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
    output logic [num_req_p-1:0]           req_ready_o,

    output logic [num_req_p-1:0]           resp_v_o,
    output logic [data_width_p-1:0]        resp_data_o,
    input  logic [num_req_p-1:0]           resp_yumi_i,

    output logic                           cache_v_o,
    output logic [pkt_width_p-1:0]         cache_pkt_o,
    input  logic                           cache_ready_i,

    input  logic                           cache_v_i,
    input  logic [data_width_p-1:0]        cache_data_i,
    output logic                           cache_yumi_o,

    input  logic                           print_stat_v_i
);

    localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w = $clog2(track_els_p + 1);
    localparam int ptr_w = (track_els_p > 1) ? $clog2(track_els_p) : 1;

    // A packed cache packet must at least hold its address and data fields.
    if (pkt_width_p < addr_width_p + data_width_p) begin : g_bad_pkt_width
        $error("pkt_width_p too small for addr_width_p + data_width_p");
    end

    // Round-robin priority pointer and tracking FIFO state.
    logic [id_w-1:0]  prio_ptr;
    logic [id_w-1:0]  fifo_mem [track_els_p];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;

    logic             full;
    logic             not_empty;
    logic             found;
    logic [id_w-1:0]  winner;
    logic [id_w-1:0]  head;
    logic             grant_ok;
    logic             push;
    logic             resp_fire;
    logic             pop;

    assign full      = (count == cnt_w'(track_els_p));
    assign not_empty = (count != '0);
    assign head      = fifo_mem[rd_ptr];

    // Scan requesters starting at the priority pointer, wrapping modulo num_req_p.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!found && req_v_i[(int'(prio_ptr) + k) % num_req_p]) begin
                found  = 1'b1;
                winner = id_w'((int'(prio_ptr) + k) % num_req_p);
            end
        end
    end

    // Request side: forward the winner's packet and grant it when the vcache accepts.
    // Outputs are held low while reset is asserted so nothing leaks out before state is valid.
    always_comb begin
        cache_v_o   = found & ~full & ~reset_i;
        grant_ok    = cache_ready_i & ~full & ~reset_i;
        cache_pkt_o = '0;
        req_ready_o = '0;
        if (found) begin
            cache_pkt_o = req_pkt_i[int'(winner)*pkt_width_p +: pkt_width_p];
            if (grant_ok) begin
                req_ready_o = num_req_p'(1) << winner;
            end
        end
    end

    assign push = cache_v_o & cache_ready_i;

    // Response side: only the requester at the FIFO head sees the response; other yumi bits are ignored.
    always_comb begin
        resp_fire    = cache_v_i & not_empty & ~reset_i;
        resp_v_o     = '0;
        cache_yumi_o = 1'b0;
        if (resp_fire) begin
            resp_v_o     = num_req_p'(1) << head;
            cache_yumi_o = resp_yumi_i[head];
        end
    end

    assign pop         = cache_yumi_o;
    assign resp_data_o = cache_data_i;

    // Pointer, FIFO pointers and occupancy only move on a handshake; push is already blocked when full.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_ptr <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                prio_ptr <= (winner == id_w'(num_req_p - 1)) ? '0 : winner + 1'b1;
                wr_ptr   <= (wr_ptr == ptr_w'(track_els_p - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == ptr_w'(track_els_p - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tracking FIFO storage; contents are only meaningful below count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= winner;
        end
    end

    // A vcache response with nothing outstanding means the vcache and arbiter are out of sync.
    a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (reset_i)
        !(cache_v_i && (count == '0)));

`ifdef VCACHE_ARB_STATS_EN
    logic [31:0] grant_ct [num_req_p];
    logic [31:0] stall_ct [num_req_p];

    // Saturating per-requester grant and stall counters.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_req_p; i++) begin
            if (reset_i) begin
                grant_ct[i] <= '0;
                stall_ct[i] <= '0;
            end else begin
                if (push && (winner == id_w'(i)) && (grant_ct[i] != 32'hFFFF_FFFF)) begin
                    grant_ct[i] <= grant_ct[i] + 32'd1;
                end
                if (req_v_i[i] && !req_ready_o[i] && (stall_ct[i] != 32'hFFFF_FFFF)) begin
                    stall_ct[i] <= stall_ct[i] + 32'd1;
                end
            end
        end
    end

    // Dump the counters away from the active edge so they reflect settled values.
    always @(negedge clk_i) begin
        if (!reset_i && print_stat_v_i) begin
            for (int i = 0; i < num_req_p; i++) begin
                $display("[BSG_INFO][VCACHE_ARB] %m req=%0d grant=%0d stall=%0d",
                         i, grant_ct[i], stall_ct[i]);
            end
        end
    end
`else
    logic unused_print_stat;
    assign unused_print_stat = print_stat_v_i;
`endif

endmodule

// File: tb/tb_vcache_req_arbiter.sv
// tb/tb_vcache_req_arbiter.sv - table-driven bench for vcache_req_arbiter
module tb_vcache_req_arbiter;

    localparam int NR = 4;
    localparam int PW = 70;
    localparam int DW = 32;

    logic                clk_i;
    logic                reset_i;
    logic [NR-1:0]       req_v_i;
    logic [NR*PW-1:0]    req_pkt_i;
    logic [NR-1:0]       req_ready_o;
    logic [NR-1:0]       resp_v_o;
    logic [DW-1:0]       resp_data_o;
    logic [NR-1:0]       resp_yumi_i;
    logic                cache_v_o;
    logic [PW-1:0]       cache_pkt_o;
    logic                cache_ready_i;
    logic                cache_v_i;
    logic [DW-1:0]       cache_data_i;
    logic                cache_yumi_o;
    logic                print_stat_v_i;

    vcache_req_arbiter #(
        .num_req_p(NR), .addr_width_p(32), .data_width_p(DW),
        .pkt_width_p(PW), .track_els_p(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_pkt_i(req_pkt_i), .req_ready_o(req_ready_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .cache_v_o(cache_v_o), .cache_pkt_o(cache_pkt_o), .cache_ready_i(cache_ready_i),
        .cache_v_i(cache_v_i), .cache_data_i(cache_data_i), .cache_yumi_o(cache_yumi_o),
        .print_stat_v_i(print_stat_v_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  req_v;
        logic        rdy;
        logic        cv;
        logic [31:0] data;
        logic [3:0]  yumi;
        logic [3:0]  e_ready;
        logic        e_cache_v;
        int          e_win;
        logic [3:0]  e_resp_v;
        logic        e_yumi;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cur    = 0;

    function automatic logic [PW-1:0] pkt_of(input int i);
        return {6'(i + 1), 32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
    endfunction

    function automatic void add(input logic [3:0] rv, input logic rdy, input logic cv,
                                input logic [31:0] d, input logic [3:0] y,
                                input logic [3:0] er, input logic ecv, input int ew,
                                input logic [3:0] erv, input logic ey);
        vec_t v;
        v.req_v = rv; v.rdy = rdy; v.cv = cv; v.data = d; v.yumi = y;
        v.e_ready = er; v.e_cache_v = ecv; v.e_win = ew; v.e_resp_v = erv; v.e_yumi = ey;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic rdy, input logic cv,
                         input logic [31:0] d, input logic [3:0] y);
        req_v_i = rv; cache_ready_i = rdy; cache_v_i = cv; cache_data_i = d; resp_yumi_i = y;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) req_pkt_i[i*PW +: PW] = pkt_of(i);
        drive(4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        print_stat_v_i = 1'b0;
        reset_i = 1'b1;

        // Fill: 0,1,2,3 then full
        add(4'h0, 0, 0, 32'h0,        4'h0, 4'h0, 0, -1, 4'h0, 0);
        add(4'hF, 1, 0, 32'h0,        4'h0, 4'h1, 1,  0, 4'h0, 0);
        add(4'hF, 1, 0, 32'h0,        4'h0, 4'h2, 1,  1, 4'h0, 0);
        add(4'hF, 1, 0, 32'h0,        4'h0, 4'h4, 1,  2, 4'h0, 0);
        add(4'hF, 1, 0, 32'h0,        4'h0, 4'h8, 1,  3, 4'h0, 0);
        add(4'hF, 1, 0, 32'h0,        4'h0, 4'h0, 0,  0, 4'h0, 0);
        // Pop head 0 while full: no bypass push this cycle
        add(4'hF, 1, 1, 32'h1111_1111, 4'h1, 4'h0, 0,  0, 4'h1, 1);
        add(4'hF, 1, 0, 32'h0,        4'h0, 4'h1, 1,  0, 4'h0, 0);
        // Non-head yumi ignored, then head pops
        add(4'hF, 1, 1, 32'h2222_2222, 4'h1, 4'h0, 0,  1, 4'h2, 0);
        add(4'h0, 0, 1, 32'h3333_3333, 4'h2, 4'h0, 0, -1, 4'h2, 1);
        add(4'h0, 0, 1, 32'h4444_4444, 4'hF, 4'h0, 0, -1, 4'h4, 1);
        // Push and pop together at count 2
        add(4'h4, 1, 1, 32'hDEAD_BEEF, 4'h8, 4'h4, 1,  2, 4'h8, 1);
        // Pointer at 3: grant 3 then wrap to 0
        add(4'h9, 1, 0, 32'h0,        4'h0, 4'h8, 1,  3, 4'h0, 0);
        add(4'h9, 1, 0, 32'h0,        4'h0, 4'h1, 1,  0, 4'h0, 0);
        // Drain in order 0,2,3,0
        add(4'h0, 0, 1, 32'h5,        4'hF, 4'h0, 0, -1, 4'h1, 1);
        add(4'h0, 0, 1, 32'h6,        4'hF, 4'h0, 0, -1, 4'h4, 1);
        add(4'h0, 0, 1, 32'h7,        4'hF, 4'h0, 0, -1, 4'h8, 1);
        add(4'h0, 0, 1, 32'h8,        4'hF, 4'h0, 0, -1, 4'h1, 1);
        add(4'h0, 0, 0, 32'h0,        4'h0, 4'h0, 0, -1, 4'h0, 0);
        // Vcache not ready for 5 cycles, then grant 2
        for (int i = 0; i < 5; i++)
            add(4'h4, 0, 0, 32'h0,    4'h0, 4'h0, 1,  2, 4'h0, 0);
        add(4'h4, 1, 0, 32'h0,        4'h0, 4'h4, 1,  2, 4'h0, 0);
        add(4'h2, 1, 0, 32'h0,        4'h0, 4'h2, 1,  1, 4'h0, 0);
        // Response held without consume, then consumed in order 2,1
        add(4'h0, 0, 1, 32'h9,        4'h0, 4'h0, 0, -1, 4'h4, 0);
        add(4'h0, 0, 1, 32'hA,        4'h4, 4'h0, 0, -1, 4'h4, 1);
        add(4'h0, 0, 1, 32'hB,        4'h2, 4'h0, 0, -1, 4'h2, 1);

        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        for (int n = 0; n < vecs.size(); n++) begin
            if (n != 0) begin
                @(posedge clk_i);
                #1;
            end
            cur = n;
            drive(vecs[n].req_v, vecs[n].rdy, vecs[n].cv, vecs[n].data, vecs[n].yumi);
            @(negedge clk_i);
            check("req_ready", PW'(req_ready_o), PW'(vecs[n].e_ready));
            check("cache_v", PW'(cache_v_o), PW'(vecs[n].e_cache_v));
            check("cache_pkt", cache_pkt_o, (vecs[n].e_win < 0) ? '0 : pkt_of(vecs[n].e_win));
            check("resp_v", PW'(resp_v_o), PW'(vecs[n].e_resp_v));
            check("cache_yumi", PW'(cache_yumi_o), PW'(vecs[n].e_yumi));
            check("resp_data", PW'(resp_data_o), PW'(vecs[n].data));
        end

        // Mid-operation reset: pointer is at 2 here
        cur = 100;
        @(posedge clk_i); #1;
        drive(4'hF, 1'b1, 1'b0, 32'h0, 4'h0);
        @(negedge clk_i);
        check("pre_reset_grant", PW'(req_ready_o), PW'(4'h4));
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(negedge clk_i);
        check("in_reset_cache_v", PW'(cache_v_o), PW'(1'b0));
        check("in_reset_ready", PW'(req_ready_o), PW'(4'h0));
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cur = 101 + k;
            @(negedge clk_i);
            check("post_reset_ready", PW'(req_ready_o), (k < 4) ? PW'(4'h1 << k) : PW'(4'h0));
            check("post_reset_cache_v", PW'(cache_v_o), PW'(k < 4));
            @(posedge clk_i); #1;
        end

        drive(4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        print_stat_v_i = 1'b1;
        @(posedge clk_i); #1;
        print_stat_v_i = 1'b0;
        @(posedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
